// File: rtl/line_fill_master.sv
// line_fill_master
//
// Fetches one 16-byte instruction-cache line (4 x 32-bit words) over AHB
// with a single 4-beat read burst and streams the returned words back to
// the cache.
//
// Build option:
//   LFM_WRAP_BURST_EN  defined   : critical-word-first. The burst starts at
//                                  miss_addr[3:2] and uses WRAP4.
//                      undefined : the burst always starts at word 0 and uses
//                                  INCR4.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   miss_req, miss_addr   line fill request and miss byte address
//   miss_ack              request accepted (same-cycle pulse)
//   busy                  fill in progress; stays high through fill_done/fill_err
//   haddr, htrans, hburst,
//   hsize, hwrite         AHB master address-phase outputs (read only)
//   hready, hresp, hrdata AHB slave response
//   fill_valid, fill_idx,
//   fill_data             returned word and its index within the line
//   fill_done             last word of the line (with final fill_valid)
//   fill_err              fill aborted on an AHB ERROR response
module line_fill_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        miss_ack,
  output logic        busy,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic [2:0]  hburst,
  output logic [2:0]  hsize,
  output logic        hwrite,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic        fill_valid,
  output logic [1:0]  fill_idx,
  output logic [31:0] fill_data,
  output logic        fill_done,
  output logic        fill_err
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBurst,
    StLast,
    StAbort
  } state_e;

  logic [1:0] start_word;
  logic       unused_addr_lsb;

`ifdef LFM_WRAP_BURST_EN
  localparam logic [2:0] BurstType = 3'b010;  // WRAP4
  assign start_word = miss_addr[3:2];
`else
  localparam logic [2:0] BurstType = 3'b011;  // INCR4
  assign start_word = 2'b00;
`endif

  // Byte offset bits never reach the bus; the line is always word-aligned.
  assign unused_addr_lsb = ^miss_addr[3:0];

  state_e      state_q;
  logic [27:0] line_q;   // miss_addr[31:4] of the fill in progress
  logic [1:0]  start_q;  // first word fetched
  logic [1:0]  acnt_q;   // beat number currently in the address phase
  logic [1:0]  dcnt_q;   // beat number currently in the data phase
  logic        dph_q;    // a data phase is outstanding on the bus

  assign hsize  = 3'b010;
  assign hwrite = 1'b0;

  // busy gates acceptance so a request arriving in the fill_done/fill_err
  // cycle waits one cycle, even though the FSM is already back in StIdle.
  assign miss_ack = rstn & (state_q == StIdle) & ~busy & miss_req;

  function automatic logic [31:0] beat_addr(input logic [27:0] line, input logic [1:0] word);
    return {line, word, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      line_q     <= '0;
      start_q    <= '0;
      acnt_q     <= '0;
      dcnt_q     <= '0;
      dph_q      <= 1'b0;
      haddr      <= '0;
      htrans     <= TransIdle;
      hburst     <= '0;
      busy       <= 1'b0;
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_data  <= '0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          busy <= 1'b0;
          if (miss_ack) begin
            state_q <= StAddr;
            busy    <= 1'b1;
            line_q  <= miss_addr[31:4];
            start_q <= start_word;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            dph_q   <= 1'b0;
            haddr   <= beat_addr(miss_addr[31:4], start_word);
            htrans  <= TransNonseq;
            hburst  <= BurstType;
          end
        end

        StAddr, StBurst: begin
          if (dph_q && hresp) begin
            // ERROR on the outstanding beat: drop the pending address phase.
            htrans <= TransIdle;
            if (hready) begin
              fill_err <= 1'b1;
              state_q  <= StIdle;
              dph_q    <= 1'b0;
              hburst   <= '0;
            end else begin
              state_q <= StAbort;
            end
          end else if (hready) begin
            if (dph_q) begin
              fill_valid <= 1'b1;
              fill_data  <= hrdata;
              fill_idx   <= start_q + dcnt_q;
              dcnt_q     <= dcnt_q + 2'd1;
            end
            // The address just accepted becomes the next data phase.
            dph_q <= 1'b1;
            if (acnt_q == 2'd3) begin
              state_q <= StLast;
              htrans  <= TransIdle;
            end else begin
              state_q <= StBurst;
              acnt_q  <= acnt_q + 2'd1;
              haddr   <= beat_addr(line_q, start_q + acnt_q + 2'd1);
              htrans  <= TransSeq;
            end
          end
        end

        StLast: begin
          // Only the final beat's data phase is left.
          if (hresp) begin
            if (hready) begin
              fill_err <= 1'b1;
              state_q  <= StIdle;
              dph_q    <= 1'b0;
              hburst   <= '0;
            end else begin
              state_q <= StAbort;
            end
          end else if (hready) begin
            fill_valid <= 1'b1;
            fill_data  <= hrdata;
            fill_idx   <= start_q + dcnt_q;
            fill_done  <= 1'b1;
            dcnt_q     <= '0;
            state_q    <= StIdle;
            dph_q      <= 1'b0;
            hburst     <= '0;
          end
        end

        StAbort: begin
          // Second cycle of the two-cycle ERROR response.
          if (hready) begin
            fill_err <= 1'b1;
            state_q  <= StIdle;
            dph_q    <= 1'b0;
            hburst   <= '0;
          end
        end

        default: begin
          state_q <= StIdle;
          htrans  <= TransIdle;
        end
      endcase
    end
  end

endmodule
